match_controller: RTL

Match-level sequencer that sits directly downstream of the ball controller and closes the loop back into it. It consumes the ball controller's `blue_score_up` / `red_score_up` toggle outputs, keeps both team scores, and decides when a match ends. It drives the ball controller's `game_initiated` (serve pulse) and `game_over` (match-end level) inputs. A start button begins each match, and every goal is followed by an automatic re-serve after a fixed delay.

---
 rtl/match_controller.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/match_controller.sv
// match_controller: match-level sequencer downstream of the ball controller.
// Counts goals from the ball controller's score toggles, decides when a match
// ends, and drives the serve pulse and match-end level back into it.
//
// Handshake note: there is no valid/ready pair here. game_initiated is a
// one-cycle pulse the ball controller must accept unconditionally; the score
// toggles are level changes, so a goal can never be dropped or duplicated.
module match_controller #(
   parameter int WIN_SCORE   = 5,
   parameter int SERVE_DELAY = 25_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_btn,
   input  logic       blue_score_up,
   input  logic       red_score_up,
   output logic       game_initiated,
   output logic       game_over,
   output logic [3:0] blue_score,
   output logic [3:0] red_score,
   output logic [1:0] winner,
   output logic       serving
);

   localparam int         CNT_W = $clog2(SERVE_DELAY + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_DELAY - 1);
   localparam logic [3:0] WIN   = 4'(WIN_SCORE);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SERVE = 2'd1,
      PLAY  = 2'd2,
      OVER  = 2'd3
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] serve_cnt;
   logic             s1, s2, s2_d;
   logic             blue_prev, red_prev;

   logic             start_edge;
   logic             blue_ev, red_ev;
   logic [3:0]       blue_next, red_next;
   logic             blue_wins, red_wins;

   // The button is asynchronous, so only the synchronized copy is edge-detected.
   assign start_edge = s2 & ~s2_d;

   // A goal is any change of the toggle level since the previous cycle.
   assign blue_ev   = blue_score_up ^ blue_prev;
   assign red_ev    = red_score_up  ^ red_prev;
   assign blue_next = blue_score + {3'b000, blue_ev};
   assign red_next  = red_score  + {3'b000, red_ev};
   assign blue_wins = (blue_next == WIN);
   assign red_wins  = (red_next  == WIN);

   // Match sequencer: synchronizer, goal tracking and the IDLE/SERVE/PLAY/OVER FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         serve_cnt      <= '0;
         s1             <= 1'b0;
         s2             <= 1'b0;
         s2_d           <= 1'b0;
         // Load the live levels so a toggle left high through reset is not a goal.
         blue_prev      <= blue_score_up;
         red_prev       <= red_score_up;
         game_initiated <= 1'b0;
         game_over      <= 1'b0;
         blue_score     <= 4'd0;
         red_score      <= 4'd0;
         winner         <= 2'b00;
         serving        <= 1'b0;
      end else begin
         s1             <= start_btn;
         s2             <= s1;
         s2_d           <= s2;
         // prev tracks the inputs in every state, so ignored toggles never resurface.
         blue_prev      <= blue_score_up;
         red_prev       <= red_score_up;
         game_initiated <= 1'b0;

         case (state)
            IDLE: begin
               blue_score <= 4'd0;
               red_score  <= 4'd0;
               game_over  <= 1'b0;
               winner     <= 2'b00;
               serving    <= 1'b0;
               if (start_edge) begin
                  state     <= SERVE;
                  serve_cnt <= '0;
                  serving   <= 1'b1;
               end
            end

            SERVE: begin
               if (serve_cnt == CNT_LAST) begin
                  state          <= PLAY;
                  serve_cnt      <= '0;
                  serving        <= 1'b0;
                  game_initiated <= 1'b1;
               end else begin
                  serve_cnt <= serve_cnt + 1'b1;
               end
            end

            PLAY: begin
               if (blue_ev || red_ev) begin
                  blue_score <= blue_next;
                  red_score  <= red_next;
                  if (blue_wins || red_wins) begin
                     state     <= OVER;
                     game_over <= 1'b1;
                     winner    <= {red_wins, blue_wins};
                  end else begin
                     state     <= SERVE;
                     serve_cnt <= '0;
                     serving   <= 1'b1;
                  end
               end
            end

            OVER: begin
               if (start_edge) begin
                  state      <= SERVE;
                  serve_cnt  <= '0;
                  serving    <= 1'b1;
                  game_over  <= 1'b0;
                  blue_score <= 4'd0;
                  red_score  <= 4'd0;
                  winner     <= 2'b00;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
